// File: rtl/bus_master_req_tx.sv
// Master-side serial bus initiator: requests the bus, frames one transaction, releases.
// Optional grant-wait timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_master_req_tx #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              bus_req_o,
  input  logic              bus_grant_i,
  output logic              ser_valid_o,
  output logic              ser_data_o,
  input  logic              rx_valid_i,
  input  logic              rx_data_i
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_MODE,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MAX_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bus_req_q, bus_req_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_data_q, ser_data_d;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
`ifdef BUS_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    rx_next              = rx_shift_q >> 1;
    rx_next[DATA_W-1]    = rx_data_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          write_d = write_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grant_i) begin
          state_d             = S_MODE;
          cnt_d               = '0;
          rx_shift_d          = '0;
          tx_d                = '0;
          tx_d[ADDR_W-1:0]    = addr_q;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      S_MODE: begin
        if (!bus_grant_i) begin
          state_d = S_REQ;
        end else begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (!bus_grant_i) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end else if (cnt_q == ADDR_LAST) begin
          cnt_d = '0;
          if (write_q) begin
            state_d          = S_WDATA;
            tx_d             = '0;
            tx_d[DATA_W-1:0] = wdata_q;
          end else begin
            state_d = S_RDATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = tx_q >> 1;
        end
      end
      S_WDATA: begin
        if (!bus_grant_i) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end else if (cnt_q == DATA_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = tx_q >> 1;
        end
      end
      S_RDATA: begin
        // Grant loss wins over a coincident rx bit; the partial word is discarded.
        if (!bus_grant_i) begin
          state_d    = S_REQ;
          cnt_d      = '0;
          rx_shift_d = '0;
        end else if (rx_valid_i) begin
          if (cnt_q == DATA_LAST) begin
            state_d    = S_RELEASE;
            cnt_d      = '0;
            rdata_d    = rx_next;
            rx_shift_d = '0;
            done_d     = 1'b1;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            rx_shift_d = rx_next;
          end
        end
      end
      S_RELEASE: begin
        if (!bus_grant_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    bus_req_d   = (state_d inside {S_REQ, S_MODE, S_ADDR, S_WDATA, S_RDATA});
    ser_valid_d = (state_d inside {S_MODE, S_ADDR, S_WDATA});
    ser_data_d  = ser_valid_d & ((state_d == S_MODE) ? write_q : tx_d[0]);
`ifdef BUS_TIMEOUT_EN
    to_cnt_d    = (state_q == S_REQ && state_d == S_REQ) ? to_cnt_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_q        <= '0;
      rx_shift_q  <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_q        <= tx_d;
      rx_shift_q  <= rx_shift_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bus_req_q   <= bus_req_d;
      ser_valid_q <= ser_valid_d;
      ser_data_q  <= ser_data_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign bus_req_o   = bus_req_q;
  assign ser_valid_o = ser_valid_q;
  assign ser_data_o  = ser_data_q;

endmodule

// File: tb/tb_bus_master_req_tx.sv
// Self-checking bench for bus_master_req_tx: transaction-level model plus directed scenarios.
module tb_bus_master_req_tx;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int TO_CYC = 10;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              bus_req_o;
  logic              bus_grant_i;
  logic              ser_valid_o;
  logic              ser_data_o;
  logic              rx_valid_i;
  logic              rx_data_i;

  int tests_run;
  int tests_failed;

  // Transaction-level model: phase 0 idle, 1 waiting for grant, 2 on the bus, 3 releasing.
  int          phase;
  int          sent;
  int          rx_got;
  int          wait_cyc;
  bit          frame[$];
  bit          is_write;
  logic [7:0]  rx_acc;
  logic [7:0]  exp_rdata;
  bit          exp_done;
  bit          exp_err;
  bit          exp_sv;

  logic [63:0] cap;
  int          cap_count;
  int          done_count;
  int          err_count;
  int          req_drops;
  bit          watch_req;

  bus_master_req_tx #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .bus_req_o   (bus_req_o),
    .bus_grant_i (bus_grant_i),
    .ser_valid_o (ser_valid_o),
    .ser_data_o  (ser_data_o),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    phase     = 0;
    sent      = 0;
    rx_got    = 0;
    wait_cyc  = 0;
    frame.delete();
    is_write  = 1'b0;
    rx_acc    = '0;
    exp_rdata = '0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
  endfunction

  function automatic void modelStep();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    case (phase)
      0: if (start_i) begin
        is_write = write_i;
        frame.delete();
        frame.push_back(write_i);
        for (int i = 0; i < ADDR_W; i++) frame.push_back(addr_i[i]);
        if (write_i) for (int i = 0; i < DATA_W; i++) frame.push_back(wdata_i[i]);
        phase    = 1;
        wait_cyc = 0;
      end
      1: if (bus_grant_i) begin
        phase  = 2;
        sent   = 0;
        rx_got = 0;
        rx_acc = '0;
      end else begin
`ifdef BUS_TIMEOUT_EN
        wait_cyc++;
        if (wait_cyc == TO_CYC) begin
          phase   = 0;
          exp_err = 1'b1;
        end
`endif
      end
      2: if (!bus_grant_i) begin
        phase    = 1;
        sent     = 0;
        rx_got   = 0;
        rx_acc   = '0;
        wait_cyc = 0;
      end else if (sent < frame.size()) begin
        sent++;
        if (sent == frame.size() && is_write) begin
          phase    = 3;
          exp_done = 1'b1;
        end
      end else if (rx_valid_i) begin
        rx_acc[rx_got] = rx_data_i;
        rx_got++;
        if (rx_got == DATA_W) begin
          exp_rdata = rx_acc;
          phase     = 3;
          exp_done  = 1'b1;
        end
      end
      default: if (!bus_grant_i) phase = 0;
    endcase
  endfunction

  // Compare process: checks the current cycle against the model, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      modelReset();
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_req", bus_req_o, 0);
      checkOutput("rst_ser_valid", ser_valid_o, 0);
      checkOutput("rst_rdata", rdata_o, 0);
    end else begin
      exp_sv = (phase == 2) && (sent < frame.size());
      checkOutput("busy", busy_o, (phase != 0));
      checkOutput("bus_req", bus_req_o, (phase == 1 || phase == 2));
      checkOutput("ser_valid", ser_valid_o, exp_sv);
      if (exp_sv) checkOutput("ser_data", ser_data_o, frame[sent]);
      checkOutput("done", done_o, exp_done);
      checkOutput("err", err_o, exp_err);
      checkOutput("rdata", rdata_o, exp_rdata);
      if (ser_valid_o && bus_grant_i) begin
        cap = {ser_data_o, cap[63:1]};
        cap_count++;
      end
      if (watch_req && !bus_req_o && !done_o) req_drops++;
      if (done_o) done_count++;
      if (err_o) err_count++;
      modelStep();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    start_i = 1'b1;
    write_i = w;
    addr_i  = a;
    wdata_i = d;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic waitCap(input int target, input int budget);
    int n = 0;
    while (cap_count < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("cap_wait", (cap_count >= target), 1);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("done_wait", (done_count >= target), 1);
  endtask

  task automatic sendRx(input logic [DATA_W-1:0] word, input bit gaps);
    for (int i = 0; i < DATA_W; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = word[i];
      tick(1);
      rx_valid_i = 1'b0;
      if (gaps) tick(1 + (i % 2));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cap          = '0;
    cap_count    = 0;
    done_count   = 0;
    err_count    = 0;
    req_drops    = 0;
    watch_req    = 1'b0;
    modelReset();
    rst         = 1'b1;
    start_i     = 1'b0;
    write_i     = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
    bus_grant_i = 1'b0;
    rx_valid_i  = 1'b0;
    rx_data_i   = 1'b0;
    tick(3);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_req", bus_req_o, 0);
    rst = 1'b0;
    tick(2);

    // Write 0x0A5 / 0x3C, grant three cycles after the request rises.
    cap_count  = 0;
    done_count = 0;
    applyStimulus(1'b1, 12'h0A5, 8'h3C);
    checkOutput("wr_req_rise", bus_req_o, 1);
    tick(2);
    bus_grant_i = 1'b1;
    waitDone(1, 60);
    checkOutput("wr_bits", cap_count, 21);
    checkOutput("wr_frame", cap[63:43], 21'h7814B);
    bus_grant_i = 1'b0;
    tick(2);
    checkOutput("wr_idle", busy_o, 0);
    checkOutput("wr_done_once", done_count, 1);

    // Read 0x123; rx bits during the header must be ignored.
    cap_count  = 0;
    done_count = 0;
    applyStimulus(1'b0, 12'h123, 8'h00);
    bus_grant_i = 1'b1;
    rx_valid_i  = 1'b1;
    rx_data_i   = 1'b1;
    waitCap(13, 60);
    rx_valid_i  = 1'b0;
    checkOutput("rd_frame", cap[63:51], 13'h0246);
    sendRx(8'h5A, 1'b1);
    waitDone(1, 20);
    checkOutput("rd_data", rdata_o, 8'h5A);
    rx_valid_i = 1'b1;
    rx_data_i  = 1'b1;
    tick(3);
    bus_grant_i = 1'b0;
    tick(3);
    rx_valid_i = 1'b0;
    checkOutput("rd_hold", rdata_o, 8'h5A);
    checkOutput("rd_done_once", done_count, 1);
    checkOutput("rd_bits", cap_count, 13);

    // Grant lost after five address bits, regranted four cycles later.
    cap_count  = 0;
    done_count = 0;
    req_drops  = 0;
    applyStimulus(1'b1, 12'h0A5, 8'h3C);
    watch_req   = 1'b1;
    bus_grant_i = 1'b1;
    waitCap(6, 40);
    bus_grant_i = 1'b0;
    tick(4);
    bus_grant_i = 1'b1;
    waitDone(1, 80);
    watch_req = 1'b0;
    checkOutput("rg_bits", cap_count, 27);
    checkOutput("rg_frame", cap[63:43], 21'h7814B);
    checkOutput("rg_req_held", req_drops, 0);
    bus_grant_i = 1'b0;
    tick(2);
    checkOutput("rg_done_once", done_count, 1);

    // start_i pulses while busy are ignored.
    cap_count  = 0;
    done_count = 0;
    applyStimulus(1'b1, 12'h3C3, 8'hA5);
    start_i = 1'b1;
    write_i = 1'b0;
    addr_i  = 12'hFFF;
    wdata_i = 8'h00;
    tick(1);
    start_i     = 1'b0;
    bus_grant_i = 1'b1;
    waitCap(5, 40);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    waitDone(1, 60);
    checkOutput("ign_frame", cap[63:43], 21'h14A787);
    checkOutput("ign_bits", cap_count, 21);
    bus_grant_i = 1'b0;
    tick(2);
    checkOutput("ign_done_once", done_count, 1);
    checkOutput("ign_idle", busy_o, 0);

    cap_count  = 0;
    done_count = 0;
    applyStimulus(1'b0, 12'h00F, 8'h00);
    checkOutput("restart_busy", busy_o, 1);
    bus_grant_i = 1'b1;
    waitCap(13, 40);
    sendRx(8'h81, 1'b0);
    waitDone(1, 20);
    checkOutput("restart_rdata", rdata_o, 8'h81);
    bus_grant_i = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of the write data.
    cap_count = 0;
    applyStimulus(1'b1, 12'h0A5, 8'h3C);
    bus_grant_i = 1'b1;
    waitCap(16, 40);
    rst = 1'b1;
    #1;
    checkOutput("arst_req", bus_req_o, 0);
    checkOutput("arst_ser_valid", ser_valid_o, 0);
    checkOutput("arst_busy", busy_o, 0);
    checkOutput("arst_rdata", rdata_o, 0);
    bus_grant_i = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    cap_count  = 0;
    done_count = 0;
    applyStimulus(1'b1, 12'h0A5, 8'h3C);
    tick(1);
    bus_grant_i = 1'b1;
    waitDone(1, 60);
    checkOutput("post_rst_frame", cap[63:43], 21'h7814B);
    checkOutput("post_rst_bits", cap_count, 21);
    bus_grant_i = 1'b0;
    tick(2);

`ifdef BUS_TIMEOUT_EN
    // Grant never arrives: the request gives up with an error pulse.
    done_count = 0;
    err_count  = 0;
    applyStimulus(1'b1, 12'h001, 8'h01);
    tick(TO_CYC);
    checkOutput("to_err_pulse", err_o, 1);
    checkOutput("to_req_low", bus_req_o, 0);
    tick(2);
    checkOutput("to_err_once", err_count, 1);
    checkOutput("to_no_done", done_count, 0);
    checkOutput("to_idle", busy_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
